// File: rtl/apb_bus_master_pkg.sv
// ============================================================================
// Module      : bus_pkg
// Description : Shared types and constants for the load/store APB bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } bus_state_t;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  function automatic int unsigned sel_bits(input int unsigned n);
    int unsigned b;
    b = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < n) b = i + 1;
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_bus_master_lsu_align.sv
// ============================================================================
// Module      : lsu_align
// Description : Byte-lane steering for stores and extraction/extension for loads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
  import bus_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic        write_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] prdata_i,
  output logic [3:0]  pstrb_o,
  output logic [31:0] pwdata_o,
  output logic [31:0] rdata_o,
  output logic        bad_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = prdata_i[{addr_lo_i, 3'b000} +: 8];
  assign w_half = prdata_i[{addr_lo_i[1], 4'b0000} +: 16];

  always_comb begin
    pstrb_o  = 4'b0000;
    pwdata_o = wdata_i;
    rdata_o  = 32'd0;
    bad_o    = 1'b0;
    if (write_i) begin
      case (funct3_i)
        LS_B: begin
          pstrb_o  = 4'b0001 << addr_lo_i;
          pwdata_o = {4{wdata_i[7:0]}};
        end
        LS_H: begin
          pstrb_o  = 4'b0011 << {addr_lo_i[1], 1'b0};
          pwdata_o = {2{wdata_i[15:0]}};
          bad_o    = addr_lo_i[0];
        end
        LS_W: begin
          pstrb_o = 4'b1111;
          bad_o   = |addr_lo_i;
        end
        default: bad_o = 1'b1;
      endcase
    end else begin
      case (funct3_i)
        LS_B:  rdata_o = {{24{w_byte[7]}}, w_byte};
        LS_BU: rdata_o = {24'd0, w_byte};
        LS_H: begin
          rdata_o = {{16{w_half[15]}}, w_half};
          bad_o   = addr_lo_i[0];
        end
        LS_HU: begin
          rdata_o = {16'd0, w_half};
          bad_o   = addr_lo_i[0];
        end
        LS_W: begin
          rdata_o = prdata_i;
          bad_o   = |addr_lo_i;
        end
        default: bad_o = 1'b1;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/apb_bus_master.sv
// ============================================================================
// Module      : apb_bus_master
// Description : Bridges RV32I load/store requests onto an APB4 bus of NUM_SLAVES slaves.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_bus_master
  import bus_pkg::*;
#(
  parameter int unsigned NUM_SLAVES      = 4,
  parameter logic [31:0] BASE_ADDR       = 32'h1000_0000,
  parameter int unsigned SLAVE_SPAN_BITS = 12,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req,
  input  logic                     write,
  input  logic [31:0]              addr,
  input  logic [31:0]              wdata,
  input  logic [2:0]               funct3,
  output logic [31:0]              rdata,
  output logic                     ready,
  output logic                     err,
  output logic [31:0]              paddr,
  output logic [31:0]              pwdata,
  output logic                     pwrite,
  output logic [3:0]               pstrb,
  output logic [NUM_SLAVES-1:0]    psel,
  output logic                     penable,
  input  logic [NUM_SLAVES*32-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]    pready,
  input  logic [NUM_SLAVES-1:0]    pslverr
);

  localparam int unsigned SEL_LOG = sel_bits(NUM_SLAVES);
  localparam int unsigned SEL_W   = (SEL_LOG == 0) ? 1 : SEL_LOG;
  localparam int unsigned MAP_LSB = SLAVE_SPAN_BITS + SEL_LOG;
  localparam int unsigned CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [NUM_SLAVES-1:0] SEL_ONE = 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  bus_state_t              state_q;
  logic [1:0]              addr_lo_q;
  logic [2:0]              funct3_q;
  logic                    write_q;
  logic [SEL_W-1:0]        sel_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [31:0]             paddr_q, pwdata_q, rdata_q;
  logic [3:0]              pstrb_q;
  logic                    pwrite_q, penable_q, ready_q, err_q;
  logic [NUM_SLAVES-1:0]   psel_q;

  logic [SEL_W-1:0] w_sel;
  logic             w_mapped;
  logic [2:0]       w_f3;
  logic [1:0]       w_lo;
  logic             w_wr;
  logic [31:0]      w_prword, w_pwdata, w_rdata;
  logic [3:0]       w_pstrb;
  logic             w_bad;

  assign w_sel    = (SEL_LOG == 0) ? '0 : addr[SLAVE_SPAN_BITS +: SEL_W];
  assign w_mapped = (addr[31:MAP_LSB] == BASE_ADDR[31:MAP_LSB]) && (32'(w_sel) < NUM_SLAVES);

  // Alignment unit sees the live request while idle and the latched one afterwards
  assign w_f3     = (state_q == IDLE) ? funct3   : funct3_q;
  assign w_lo     = (state_q == IDLE) ? addr[1:0] : addr_lo_q;
  assign w_wr     = (state_q == IDLE) ? write    : write_q;
  assign w_prword = prdata[32*sel_q +: 32];

  lsu_align u_lsu_align (
    .funct3_i  (w_f3),
    .write_i   (w_wr),
    .addr_lo_i (w_lo),
    .wdata_i   (wdata),
    .prdata_i  (w_prword),
    .pstrb_o   (w_pstrb),
    .pwdata_o  (w_pwdata),
    .rdata_o   (w_rdata),
    .bad_o     (w_bad)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_lo_q <= 2'd0;
      funct3_q  <= 3'd0;
      write_q   <= 1'b0;
      sel_q     <= '0;
      cnt_q     <= '0;
      paddr_q   <= 32'd0;
      pwdata_q  <= 32'd0;
      rdata_q   <= 32'd0;
      pstrb_q   <= 4'd0;
      pwrite_q  <= 1'b0;
      penable_q <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      psel_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            addr_lo_q <= addr[1:0];
            funct3_q  <= funct3;
            write_q   <= write;
            sel_q     <= w_sel;
            cnt_q     <= '0;
            if (w_mapped && !w_bad) begin
              state_q  <= SETUP;
              psel_q   <= SEL_ONE << w_sel;
              paddr_q  <= {addr[31:2], 2'b00};
              pwdata_q <= w_pwdata;
              pwrite_q <= write;
              pstrb_q  <= w_pstrb;
            end else begin
              state_q <= DONE;
              ready_q <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= 32'd0;
            end
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (pready[sel_q]) begin
            rdata_q   <= w_rdata;
            err_q     <= pslverr[sel_q];
            ready_q   <= 1'b1;
            psel_q    <= '0;
            penable_q <= 1'b0;
            state_q   <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            rdata_q   <= 32'd0;
            err_q     <= 1'b1;
            ready_q   <= 1'b1;
            psel_q    <= '0;
            penable_q <= 1'b0;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rdata   = rdata_q;
  assign ready   = ready_q;
  assign err     = err_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign pwrite  = pwrite_q;
  assign pstrb   = pstrb_q;
  assign psel    = psel_q;
  assign penable = penable_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_bus_master.sv
// ============================================================================
// Module      : tb_apb_bus_master
// Description : Randomized self-checking bench for apb_bus_master with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_bus_master;

  localparam int          NS   = 4;
  localparam int          TO   = 255;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic          clk = 1'b0;
  logic          reset, req, write;
  logic [31:0]   addr, wdata, rdata, paddr, pwdata;
  logic [2:0]    funct3;
  logic          ready, err, pwrite, penable;
  logic [3:0]    pstrb;
  logic [NS-1:0] psel, pready, pslverr;
  logic [NS*32-1:0] prdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  apb_bus_master #(
    .NUM_SLAVES(NS), .BASE_ADDR(BASE), .SLAVE_SPAN_BITS(12), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .write(write), .addr(addr), .wdata(wdata),
    .funct3(funct3), .rdata(rdata), .ready(ready), .err(err), .paddr(paddr),
    .pwdata(pwdata), .pwrite(pwrite), .pstrb(pstrb), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: legality, lanes and load extension from the access rules
  function automatic bit m_legal(input bit wr, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    if ((a >> 14) != (BASE >> 14)) return 1'b0;
    if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
    if (!wr && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    sz = int'(f3) % 4;
    if (sz == 1 && (a % 2) != 0) return 1'b0;
    if (sz == 2 && (a % 4) != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_strb(input bit wr, input logic [2:0] f3, input logic [31:0] a);
    int sz = int'(f3) % 4;
    if (!wr) return 0;
    if (sz == 0) return 32'd1 << (a % 4);
    if (sz == 1) return 32'd3 << (a % 4);
    return 32'd15;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int sz = int'(f3) % 4;
    if (sz == 0) return (wd % 256) * 32'h0101_0101;
    if (sz == 1) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] prd);
    logic [31:0] v = prd >> (8 * (a % 4));
    case (f3)
      3'd0: return (v % 256) >= 128 ? (v % 256) + 32'hFFFF_FF00 : v % 256;
      3'd4: return v % 256;
      3'd1: return (v % 65536) >= 32768 ? (v % 65536) + 32'hFFFF_0000 : v % 65536;
      3'd5: return v % 65536;
      default: return prd;
    endcase
  endfunction

  task automatic run(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [2:0] f3, input int waits, input bit serr,
                     input logic [31:0] prd, input string tag);
    bit            ok = m_legal(wr, f3, a);
    int            s = int'((a >> 12) % 4);
    logic [NS-1:0] onehot = NS'(1) << s;
    int            acc = 0, cyc = 0;
    bit            got = 1'b0, saw_psel = 1'b0;
    int            exp_cyc, exp_acc;
    logic [31:0]   exp_rd;
    bit            chk_rd;
    for (int i = 0; i < NS; i++) prdata[i*32 +: 32] = $urandom;
    pslverr = NS'($urandom);
    pready  = NS'($urandom) & ~onehot;
    pslverr[s] = serr;
    prdata[s*32 +: 32] = prd;
    @(negedge clk);
    req = 1'b1; write = wr; addr = a; wdata = wd; funct3 = f3;
    while (!got && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (psel != 0) saw_psel = 1'b1;
      if (ok && cyc == 1) begin
        check_eq({tag, "_setup_psel"}, 32'(psel), 32'(onehot));
        check_eq({tag, "_setup_penable"}, 32'(penable), 0);
        check_eq({tag, "_paddr"}, paddr, a & 32'hFFFF_FFFC);
        check_eq({tag, "_pwrite"}, 32'(pwrite), 32'(wr));
        check_eq({tag, "_pstrb"}, 32'(pstrb), m_strb(wr, f3, a));
        if (wr) check_eq({tag, "_pwdata"}, pwdata, m_wdata(f3, wd));
      end
      if (penable) begin
        acc++;
        if (acc == 1) check_eq({tag, "_access_psel"}, 32'(psel), 32'(onehot));
        pready[s] = (acc > waits);
      end
      if (ready) got = 1'b1;
    end
    req = 1'b0;
    pready = '0;
    check_eq({tag, "_completed"}, 32'(got), 1);
    chk_rd = 1'b1;
    if (!ok) begin
      exp_cyc = 1; exp_acc = 0; exp_rd = 0;
      check_eq({tag, "_err"}, 32'(err), 1);
      check_eq({tag, "_no_psel"}, 32'(saw_psel), 0);
    end else if (waits >= TO) begin
      exp_cyc = TO + 2; exp_acc = TO; exp_rd = 0;
      check_eq({tag, "_err"}, 32'(err), 1);
    end else begin
      exp_cyc = 3 + waits; exp_acc = waits + 1;
      exp_rd = m_load(f3, a, prd);
      chk_rd = !wr;
      check_eq({tag, "_err"}, 32'(err), 32'(serr));
    end
    check_eq({tag, "_latency"}, cyc, exp_cyc);
    check_eq({tag, "_access_cycles"}, acc, exp_acc);
    check_eq({tag, "_done_psel"}, 32'(psel), 0);
    if (chk_rd) check_eq({tag, "_rdata"}, rdata, exp_rd);
    @(negedge clk);
    check_eq({tag, "_ready_pulse"}, 32'(ready), 0);
    if (chk_rd) check_eq({tag, "_rdata_hold"}, rdata, exp_rd);
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  f3;
    bit          wr;
    int          waits, n;
    reset = 1'b1; req = 1'b0; write = 1'b0; addr = 0; wdata = 0; funct3 = 0;
    prdata = '0; pready = '0; pslverr = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", 32'(ready), 0);
    check_eq("rst_err", 32'(err), 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_psel", 32'(psel), 0);
    check_eq("rst_penable", 32'(penable), 0);
    check_eq("rst_paddr", paddr, 0);
    check_eq("rst_pstrb", 32'(pstrb), 0);
    reset = 1'b0;

    run(1, 32'h1000_1000, 32'hDEAD_BEEF, 3'b010, 0, 0, 32'h0, "sw_s1");
    run(1, 32'h1000_0003, 32'h0000_00A5, 3'b000, 0, 0, 32'h0, "sb");
    run(0, 32'h1000_0003, 32'h0, 3'b000, 0, 0, 32'h8000_0000, "lb");
    run(0, 32'h1000_0003, 32'h0, 3'b100, 0, 0, 32'h8000_0000, "lbu");
    run(0, 32'h1000_2002, 32'h0, 3'b001, 3, 0, 32'h8001_1234, "lh_wait");
    run(0, 32'h1000_0002, 32'h0, 3'b010, 0, 0, 32'h1234_5678, "lw_misalign");
    run(1, 32'h2000_0000, 32'h1, 3'b010, 0, 0, 32'h0, "sw_unmapped");
    run(0, 32'h1000_0000, 32'h0, 3'b011, 0, 0, 32'h0, "bad_funct3");
    run(0, 32'h1000_3000, 32'h0, 3'b010, TO, 0, 32'h5555_AAAA, "timeout");
    run(0, 32'h1000_1004, 32'h0, 3'b010, 1, 1, 32'h0BAD_F00D, "slverr");

    // Reset while the slave is stalling in ACCESS
    for (int i = 0; i < NS; i++) prdata[i*32 +: 32] = $urandom;
    pready = '0; pslverr = '0;
    @(negedge clk);
    req = 1'b1; write = 1'b1; addr = 32'h1000_1000; wdata = 32'h1357_9BDF; funct3 = 3'b010;
    n = 0;
    for (int i = 0; i < 10 && n < 2; i++) begin
      @(negedge clk);
      if (penable) n++;
    end
    check_eq("rst_mid_reached_access", n, 2);
    reset = 1'b1; req = 1'b0;
    #1;
    check_eq("rst_mid_psel", 32'(psel), 0);
    check_eq("rst_mid_penable", 32'(penable), 0);
    check_eq("rst_mid_paddr", paddr, 0);
    check_eq("rst_mid_pwdata", pwdata, 0);
    check_eq("rst_mid_pstrb", 32'(pstrb), 0);
    check_eq("rst_mid_pwrite", 32'(pwrite), 0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 1) reset = 1'b0;
      if (ready) n++;
    end
    check_eq("rst_mid_no_ready", n, 0);
    run(1, 32'h1000_1000, 32'hCAFE_F00D, 3'b010, 0, 0, 32'h0, "sw_after_rst");

    for (int k = 0; k < 150; k++) begin
      wr = 1'($urandom);
      a  = BASE + (($urandom % 4) << 12) + ($urandom % 4096);
      if ($urandom % 8 == 0) a = $urandom;
      if ($urandom % 6 == 0) f3 = 3'($urandom);
      else if (wr) f3 = 3'($urandom % 3);
      else begin
        n = $urandom % 5;
        f3 = (n < 3) ? 3'(n) : 3'(n + 1);
      end
      // Keep most random accesses aligned so the APB path gets exercised
      if ($urandom % 4 != 0) begin
        if (int'(f3) % 4 == 1) a = a & 32'hFFFF_FFFE;
        if (int'(f3) % 4 == 2) a = a & 32'hFFFF_FFFC;
      end
      waits = ($urandom % 40 == 0) ? TO : int'($urandom % 4);
      run(wr, a, $urandom, f3, waits, ($urandom % 6 == 0), $urandom, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/apb_bus_master.md
Name: apb_bus_master

Overview:
- Load/store bus bridge directly downstream of the RV32I datapath.
- Consumes the datapath's bus request (busAddr/busWData/funct3) and returns busRData to it.
- Converts each load/store into one APB transfer to one of NUM_SLAVES memory-mapped peripherals, with store byte strobes and load sign/zero extension.
- Asserts ready for exactly one cycle per completed access; the controller gates the PC enable with it (the core stalls while a bus access is outstanding).

Parameters:
- NUM_SLAVES, 4, number of APB slaves; psel width.
- BASE_ADDR, 32'h1000_0000, base of the peripheral region.
- SLAVE_SPAN_BITS, 12, each slave owns 2**SLAVE_SPAN_BITS bytes. Slave i occupies BASE_ADDR + i*2**SLAVE_SPAN_BITS.
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles waiting for pready before an error completion.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req  in  1  bus access request, held until ready
- write  in  1  1 = store, 0 = load
- addr  in  32  byte address (busAddr)
- wdata  in  32  store data (busWData), right-aligned
- funct3  in  3  access size/sign, RV32I load/store encoding
- rdata  out  32  extended load data (busRData), valid while ready=1
- ready  out  1  one-cycle completion pulse
- err  out  1  valid with ready; 1 = decode/misalign/slave error/timeout
- paddr  out  32  APB address, word-aligned ({addr[31:2],2'b00})
- pwdata  out  32  APB write data, lane-replicated
- pwrite  out  1  APB direction
- pstrb  out  4  APB4 byte strobes; 0 on reads
- psel  out  NUM_SLAVES  one-hot slave select
- penable  out  1  APB enable
- prdata  in  NUM_SLAVES*32  flattened slave read data; slave i at [i*32+:32]
- pready  in  NUM_SLAVES  per-slave ready
- pslverr  in  NUM_SLAVES  per-slave error

Behaviour:
- Reset:
  - asynchronous; FSM to IDLE.
  - rdata=0, ready=0, err=0, psel=0, penable=0, pwrite=0, pstrb=0, paddr=0, pwdata=0, timeout counter=0.
  - Reset mid-transfer aborts immediately. No completion pulse is issued.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - If req=1, latch addr/wdata/write/funct3 and decode.
  - Legal and mapped access -> SETUP.
  - Otherwise -> DONE with err=1, rdata=0, no APB activity.
- SETUP (1 cycle):
  - psel[sel]=1, penable=0; paddr/pwdata/pwrite/pstrb driven from the latched request.
  - -> ACCESS.
- ACCESS:
  - psel[sel]=1, penable=1; APB outputs stable.
  - pready[sel]=1: capture extended prdata[sel] into rdata, err=pslverr[sel], -> DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES -> DONE with err=1, rdata=0.
  - psel/penable drop to 0 on leaving ACCESS.
- DONE (1 cycle):
  - ready=1; rdata/err valid; -> IDLE.
  - A req still high in this cycle is ignored. A new request is sampled in IDLE on the following cycle.
- Latency with zero-wait slave: req sampled in IDLE at cycle 0, SETUP at 1, ACCESS at 2, ready at 3. Each wait state adds 1 cycle.
- Error/decode completion: ready at cycle 1.
- rdata and err hold their value after DONE until the next completion.
- Decode:
  - Mapped iff addr[31:SLAVE_SPAN_BITS+clog2(NUM_SLAVES)] equals the same bits of BASE_ADDR.
  - sel = addr[SLAVE_SPAN_BITS +: clog2(NUM_SLAVES)].
- Legal funct3 values:
  - store: 000 SB, 001 SH, 010 SW.
  - load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - All others -> err.
- Misalignment -> err:
  - half access with addr[0]=1.
  - word access with addr[1:0]!=0.
- Store lanes:
  - SB: pstrb=4'b0001<<addr[1:0]; pwdata={4{wdata[7:0]}}.
  - SH: pstrb=4'b0011<<{addr[1],1'b0}; pwdata={2{wdata[15:0]}}.
  - SW: pstrb=4'b1111; pwdata=wdata.
- Load extract: byte at prdata[addr[1:0]*8+:8], half at prdata[addr[1]*16+:16]. Sign-extend for LB/LH, zero-extend for LBU/LHU.
- prdata/pready/pslverr of non-selected slaves are ignored.

Decomposition:
- Shared package bus_pkg:
  - FSM enum bus_state_t (IDLE, SETUP, ACCESS, DONE).
  - funct3 constants LS_B, LS_H, LS_W, LS_BU, LS_HU.
  - helper function for clog2 of NUM_SLAVES.
- One combinational sub-module lsu_align:
  - inputs: funct3, addr[1:0], wdata, raw prdata word.
  - outputs: pstrb, pwdata, extended rdata, misalign/illegal flag.
- The FSM, decode and timeout counter stay in apb_bus_master.

Test Plan:
- SW addr=0x1000_1000, wdata=0xDEADBEEF, slave1 pready=1 immediately -> psel=4'b0010 at cycles 1-2, penable=1 at cycle 2, pstrb=4'b1111, paddr=0x1000_1000, ready=1 err=0 at cycle 3.
- SB addr=0x1000_0003, wdata=0x000000A5 -> pstrb=4'b1000, pwdata=0xA5A5A5A5. LB same address, prdata=0x80000000 -> rdata=0xFFFFFF80; LBU -> rdata=0x00000080.
- LH addr=0x1000_2002 with slave2 holding pready=0 for 3 ACCESS cycles, prdata=0x8001_1234 -> penable high 4 cycles, ready at cycle 6, rdata=0xFFFF8001.
- Errors, no psel ever asserted, ready=1 err=1 rdata=0 at cycle 1:
  - LW addr=0x1000_0002 (misaligned).
  - SW addr=0x2000_0000 (unmapped).
  - funct3=011.
- Slave3 never asserts pready -> err=1 after exactly TIMEOUT_CYCLES ACCESS cycles, psel cleared. pslverr=1 with pready=1 -> err=1 on ready.
- Reset asserted during ACCESS -> all APB outputs 0 immediately, no ready pulse. A subsequent SW completes normally at cycle 3.
